// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: command opcodes and
// sequencer states, plus a helper that classifies the positional ops.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_SHR   = 3'd2,
        OP_SHL   = 3'd3,
        OP_ROR   = 3'd4,
        OP_ROL   = 3'd5,
        OP_CLEAR = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift_op(input op_e op);
        return op inside {OP_SHR, OP_SHL, OP_ROR, OP_ROL};
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// One-position shift/rotate of q; purely combinational. Non-positional ops
// pass q through unchanged with out_bit = 0.
import shift_pkg::*;

module usr_shift_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] q,
    input  logic [2:0]   op,
    input  logic         serial_in_msb,
    input  logic         serial_in_lsb,
    output logic [N-1:0] next_q,
    output logic         out_bit
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        next_q  = q;
        out_bit = 1'b0;
        case (op_e'(op))
            OP_SHR: begin
                next_q  = {serial_in_msb, q[N-1:1]};
                out_bit = q[0];
            end
            OP_SHL: begin
                next_q  = {q[N-2:0], serial_in_lsb};
                out_bit = q[N-1];
            end
            OP_ROR: begin
                next_q  = {q[0], q[N-1:1]};
                out_bit = q[0];
            end
            OP_ROL: begin
                next_q  = {q[N-2:0], q[N-1]};
                out_bit = q[N-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal N-bit shift register: a command is accepted in IDLE, shift and
// rotate commands run cmd_count positions (one per clock), then DONE pulses.
import shift_pkg::*;

module univ_shift_reg #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [N-1:0]     par_in,
    input  logic             serial_in_msb,
    input  logic             serial_in_lsb,
    output logic [N-1:0]     q,
    output logic             serial_out,
    output logic             serial_out_valid,
    output logic             busy,
    output logic             done
);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    op_e              op_r;
    op_e              cmd_op_e;
    op_e              step_op;
    logic             accept;
    logic             shift_now;
    logic [N-1:0]     step_q;
    logic             step_bit;
    logic [N-1:0]     q_nxt;

    assign cmd_op_e  = op_e'(cmd_op);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign accept    = cmd_valid && cmd_ready;

    // The accept edge already performs the first shift, so the live opcode is
    // used there and the latched one afterwards.
    assign step_op   = (state == ST_SHIFT) ? op_r : cmd_op_e;
    assign shift_now = (state == ST_SHIFT) ||
                       (accept && is_shift_op(cmd_op_e) && cmd_count != '0);

    usr_shift_step #(.N(N)) u_step (
        .q             (q),
        .op            (step_op),
        .serial_in_msb (serial_in_msb),
        .serial_in_lsb (serial_in_lsb),
        .next_q        (step_q),
        .out_bit       (step_bit)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = q;
        if (shift_now) begin
            q_nxt = step_q;
        end else if (accept && cmd_op_e == OP_LOAD) begin
            q_nxt = par_in;
        end else if (accept && cmd_op_e == OP_CLEAR) begin
            q_nxt = '0;
        end
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (shift_now) begin
                        cnt_nxt   = cmd_count - CNT_W'(1);
                        state_nxt = (cmd_count == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            op_r             <= OP_NOP;
            q                <= '0;
            serial_out       <= 1'b0;
            serial_out_valid <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            q                <= q_nxt;
            serial_out_valid <= shift_now;
            if (accept) begin
                op_r <= cmd_op_e;
            end
            if (shift_now) begin
                serial_out <= step_bit;
            end
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus random
// commands, checked cycle by cycle against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int N     = 8;
    localparam int CNT_W = 4;
    localparam int MODV  = 1 << N;
    localparam int TOPW  = 1 << (N - 1);

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [N-1:0]     par_in;
    logic             serial_in_msb;
    logic             serial_in_lsb;
    logic [N-1:0]     q;
    logic             serial_out;
    logic             serial_out_valid;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;
    int m_q     = 0;
    int m_so    = 0;

    univ_shift_reg #(.N(N), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_count        (cmd_count),
        .par_in           (par_in),
        .serial_in_msb    (serial_in_msb),
        .serial_in_lsb    (serial_in_lsb),
        .q                (q),
        .serial_out       (serial_out),
        .serial_out_valid (serial_out_valid),
        .busy             (busy),
        .done             (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one position of movement expressed as integer arithmetic.
    task automatic model_step(input int op, input int msb, input int lsb);
        case (op)
            2: begin m_so = m_q % 2;    m_q = (m_q / 2) + msb * TOPW;        end
            3: begin m_so = m_q / TOPW; m_q = ((m_q * 2) % MODV) + lsb;      end
            4: begin m_so = m_q % 2;    m_q = (m_q / 2) + m_so * TOPW;       end
            5: begin m_so = m_q / TOPW; m_q = ((m_q * 2) % MODV) + m_so;     end
            default: ;
        endcase
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_q"}, q, m_q);
        check({tag, "_so"}, serial_out, m_so);
        check({tag, "_sov"}, serial_out_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rdy"}, cmd_ready, 1);
    endtask

    // Called at a negedge with the DUT idle. sel = 2 picks a random serial bit.
    // With junk set, a CLEAR stays on the command bus while the DUT is busy.
    task automatic run_cmd(input int op, input int cnt, input int par,
                           input int msb_sel, input int lsb_sel, input bit junk);
        int k;
        int edges;
        int m;
        int l;
        k     = (op >= 2 && op <= 5) ? cnt : 0;
        edges = (k == 0) ? 1 : k;
        check("pre_rdy", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_count = CNT_W'(cnt);
        par_in    = N'(par);
        for (int e = 0; e < edges; e++) begin
            m = (msb_sel == 2) ? int'($urandom % 2) : msb_sel;
            l = (lsb_sel == 2) ? int'($urandom % 2) : lsb_sel;
            serial_in_msb = m[0];
            serial_in_lsb = l[0];
            @(posedge clk);
            @(negedge clk);
            if (e == 0) begin
                if (op == 1) m_q = par % MODV;
                else if (op == 6) m_q = 0;
                par_in    = N'($urandom);
                cmd_count = CNT_W'($urandom);
                if (junk) cmd_op = 3'd6;
                else begin
                    cmd_op    = 3'($urandom);
                    cmd_valid = 1'b0;
                end
            end
            if (k > 0) model_step(op, m, l);
            check("run_q", q, m_q);
            check("run_so", serial_out, m_so);
            check("run_sov", serial_out_valid, (k > 0) ? 1 : 0);
            check("run_done", done, (e == edges - 1) ? 1 : 0);
            check("run_busy", busy, 1);
            check("run_rdy", cmd_ready, 0);
        end
        serial_in_msb = 1'($urandom);
        serial_in_lsb = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        check_idle("post");
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_op        = 3'd0;
        cmd_count     = '0;
        par_in        = '0;
        serial_in_msb = 1'b0;
        serial_in_lsb = 1'b0;
        #2 reset = 1'b0;
        #1 check_idle("rst0");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Asynchronous reset between edges takes effect immediately.
        run_cmd(1, 0, 8'h5A, 0, 0, 1'b0);
        #2 reset = 1'b0;
        #1;
        m_q = 0; m_so = 0;
        check_idle("async_rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_cmd(1, 0, 8'hA5, 0, 0, 1'b0);
        check("t2_q", q, 8'hA5);
        run_cmd(2, 3, 0, 1, 0, 1'b0);
        check("t3_q", q, 8'hF4);
        run_cmd(1, 0, 8'h81, 0, 0, 1'b0);
        run_cmd(3, 2, 0, 0, 0, 1'b0);
        check("t4_q", q, 8'h04);
        run_cmd(1, 0, 8'h3C, 0, 0, 1'b0);
        run_cmd(5, 8, 0, 2, 2, 1'b1);
        check("t5_q", q, 8'h3C);
        run_cmd(6, 0, 8'hFF, 0, 0, 1'b0);
        check("t5_clr", q, 8'h00);

        for (int i = 0; i < 60; i++) begin
            run_cmd(int'($urandom % 8), int'($urandom % 16), int'($urandom % MODV),
                    2, 2, 1'($urandom));
        end

        // Reset in the middle of a 5-position shift aborts without done.
        run_cmd(1, 0, 8'h96, 0, 0, 1'b0);
        cmd_valid     = 1'b1;
        cmd_op        = 3'd2;
        cmd_count     = CNT_W'(5);
        serial_in_msb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t6_mid_busy", busy, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        m_q = 0; m_so = 0;
        check_idle("t6_rst");
        @(posedge clk);
        @(negedge clk);
        check_idle("t6_hold");
        reset = 1'b1;
        @(negedge clk);
        check_idle("t6_rel");

        run_cmd(1, 0, 8'h6B, 0, 0, 1'b0);
        run_cmd(3, 0, 0, 1, 1, 1'b0);
        check("t6_shl0_q", q, 8'h6B);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised N-bit universal shift register with a command handshake. It is the next generation of the single-step bidirectional shift register. It adds parallel load, clear, logical shift in either direction, and rotate in either direction. Each shift or rotate command runs a programmable number of positions, one per clock, under an internal sequencer. It serves as the serial/parallel conversion and bit-alignment building block in the shift-register library.

Parameters:
N, 8, register width in bits (N >= 2)
CNT_W, $clog2(N+1), width of the position-count field

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command; combinational, equals (state == IDLE)
cmd_op  input  3  0 NOP, 1 LOAD, 2 SHR, 3 SHL, 4 ROR, 5 ROL, 6 CLEAR, 7 reserved (treated as NOP)
cmd_count  input  CNT_W  number of positions for SHR/SHL/ROR/ROL
par_in  input  N  parallel load data
serial_in_msb  input  1  fill bit entering q[N-1] on SHR
serial_in_lsb  input  1  fill bit entering q[0] on SHL
q  output  N  register contents
serial_out  output  1  bit shifted or rotated out on the most recent shift edge
serial_out_valid  output  1  one-cycle pulse; high in the cycle after each shift edge
busy  output  1  high in SHIFT and DONE states
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset = 0, asynchronous):
  - q = 0, state = IDLE, count = 0.
  - serial_out = 0, serial_out_valid = 0, done = 0, busy = 0, cmd_ready = 1.
- Reset asserted mid-command aborts the command immediately. No done pulse is produced.
- States: IDLE, SHIFT, DONE.
- A command is accepted on an edge where cmd_valid && cmd_ready. The block samples cmd_op, cmd_count and par_in only on that edge.
- While busy, cmd_valid is ignored. A held command is accepted in the first IDLE cycle.
- Per-edge shift operations:
  - SHR: q <= {serial_in_msb, q[N-1:1]}; serial_out <= q[0].
  - SHL: q <= {q[N-2:0], serial_in_lsb}; serial_out <= q[N-1].
  - ROR: q <= {q[0], q[N-1:1]}; serial_out <= q[0].
  - ROL: q <= {q[N-2:0], q[N-1]}; serial_out <= q[N-1].
  - Serial inputs are sampled on every shift edge, not only at accept.
  - serial_in_msb and serial_in_lsb are ignored for rotates.
- LOAD, CLEAR, NOP, reserved op, or any shift/rotate with cmd_count = 0:
  - On the accept edge: q <= par_in (LOAD), q <= 0 (CLEAR), otherwise unchanged.
  - Go to DONE.
- Shift/rotate with cmd_count = k >= 1:
  - The accept edge performs shift 1 and loads count = k-1.
  - If k = 1, go to DONE; otherwise go to SHIFT.
  - In SHIFT, each edge performs one shift and decrements count. The edge performing shift k goes to DONE.
  - Exactly k shifts occur on k consecutive edges.
  - k is not clamped to N. Rotate by N restores the original q. Shift by N or more fills q entirely with serial input bits.
- DONE lasts exactly one cycle with done = 1, then returns to IDLE. Accept-to-done latency is max(k,1) cycles.
- serial_out holds its value between shifts. serial_out_valid is high only in the cycle after a shift edge.
- q holds its value whenever no operation is executing.

Decomposition:
- Shared package shift_pkg holds:
  - the op encodings (OP_NOP, OP_LOAD, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_CLEAR);
  - the state encoding (ST_IDLE, ST_SHIFT, ST_DONE).
- One natural sub-module: usr_shift_step, a purely combinational next-value function. It takes q, op, serial_in_msb and serial_in_lsb, and produces next_q and out_bit.
- The sequencer, count and registers stay in univ_shift_reg.

Test Plan:
1. Reset asserted asynchronously between clock edges -> q = 0x00, cmd_ready = 1, busy = 0, done = 0 immediately, without waiting for a clock edge.
2. LOAD par_in = 0xA5 -> q = 0xA5 after the accept edge; done pulses for one cycle on the next edge; cmd_ready returns one cycle later.
3. From 0xA5, SHR count = 3 with serial_in_msb = 1 -> q steps through 0xD2, 0xE9, 0xF4; serial_out = 1, 0, 1 with three valid pulses; done in the cycle after the third shift.
4. From 0x81, SHL count = 2 with serial_in_lsb = 0 -> q steps through 0x02, 0x04; serial_out = 1, 0.
5. From 0x3C, ROL count = 8 -> q returns to 0x3C after 8 edges; serial_out sequence = 0,0,1,1,1,1,0,0. A second cmd_valid with CLEAR asserted during busy is ignored until IDLE, then q = 0x00.
6. Start SHR count = 5; assert reset after 2 shifts -> q = 0x00, state IDLE, no done pulse. Also: a SHL command with count = 0 leaves q unchanged and pulses done after 1 cycle.
